// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the paced segment-display character sender.
package seg_pkg;

    localparam int unsigned CHAR_W            = 7;
    localparam int unsigned DEPTH_DEFAULT     = 8;
    localparam int unsigned GAP_TICKS_DEFAULT = 30;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } seg_state_t;

endpackage

// File: rtl/seg_char_fifo.sv
// Character FIFO for seg_char_sender: storage, pointers, count, registered full/empty
// and sticky overflow. loop_en turns each read into a read-and-requeue of the head.
module seg_char_fifo
    import seg_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              rd_en,
    input  logic              clear,
    input  logic              loop_en,
    output logic [CHAR_W-1:0] rd_char,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CHAR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              wr_ok;
    logic              push;
    logic [CHAR_W-1:0] push_char;

    assign rd_char = mem[rd_ptr];

    // full is the pre-edge flag, so a same-cycle read never makes room for a write
    always_comb begin
        wr_ok     = wr_en && !full && !clear && !loop_en;
        push      = wr_ok || (loop_en && rd_en && !clear);
        push_char = loop_en ? rd_char : wr_char;
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (push && !rd_en) begin
            count_nxt = count + CW'(1);
        end else if (rd_en && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (rd_en) rd_ptr <= rd_ptr + AW'(1);
                if (push)  wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            if (clear) begin
                overflow <= 1'b0;
            end else if (wr_en && full && !loop_en) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_char;
    end

endmodule

// File: rtl/seg_char_sender.sv
// Paces queued characters to the segment animator, one strobe per GAP_TICKS ticks.
// Optional recirculate mode (loop_en port) is enabled by defining SEG_SENDER_LOOP_EN.
module seg_char_sender
    import seg_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    parameter int unsigned GAP_TICKS = GAP_TICKS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_char,
    input  logic              clear,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              char_available,
    output logic [CHAR_W-1:0] char_out,
    output logic              busy
`ifdef SEG_SENDER_LOOP_EN
    ,
    input  logic              loop_en
`endif
);

    localparam logic [7:0] LAST_TICK = 8'(GAP_TICKS - 1);

    seg_state_t        state;
    seg_state_t        state_nxt;
    logic [7:0]        tick_cnt;
    logic [7:0]        tick_cnt_nxt;
    logic              pop;
    logic              loop_mode;
    logic [CHAR_W-1:0] head_char;

`ifdef SEG_SENDER_LOOP_EN
    assign loop_mode = loop_en;
`else
    assign loop_mode = 1'b0;
`endif

    seg_char_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_char  (wr_char),
        .rd_en    (pop),
        .clear    (clear),
        .loop_en  (loop_mode),
        .rd_char  (head_char),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    assign busy = (state != IDLE);

    // A tick coinciding with the strobe cycle is ignored so the gap starts after the strobe
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    state_nxt    = GAP;
                    tick_cnt_nxt = '0;
                end
            end
            GAP: begin
                if (tick && !char_available) begin
                    if (tick_cnt == LAST_TICK) begin
                        state_nxt = IDLE;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            char_out       <= '0;
            char_available <= 1'b0;
        end else begin
            state          <= state_nxt;
            tick_cnt       <= tick_cnt_nxt;
            char_available <= pop;
            if (pop) char_out <= head_char;
        end
    end

endmodule

// File: tb/tb_seg_char_sender.sv
// Self-checking bench for seg_char_sender against a queue-based behavioural model.
module tb_seg_char_sender;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       wr_en;
    logic [6:0] wr_char;
    logic       clear;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       char_available;
    logic [6:0] char_out;
    logic       busy;
`ifdef SEG_SENDER_LOOP_EN
    logic       loop_en;
`endif

    always #5 clk = ~clk;

    seg_char_sender #(
        .DEPTH     (DEPTH),
        .GAP_TICKS (GAP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .wr_en          (wr_en),
        .wr_char        (wr_char),
        .clear          (clear),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow),
        .char_available (char_available),
        .char_out       (char_out),
        .busy           (busy)
`ifdef SEG_SENDER_LOOP_EN
        ,
        .loop_en        (loop_en)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // behavioural model: a queue of pending characters plus a pacing window
    logic [6:0] m_q[$];
    bit         m_gap    = 1'b0;
    int         m_ticks  = 0;
    bit         m_strobe = 1'b0;
    logic [6:0] m_char   = '0;
    bit         m_ovf    = 1'b0;

    logic [6:0] log_q[$];
    int         last_cyc    = -1;
    int         ticks_since = 0;
    bit         seen        = 1'b0;
    bit         exact_gap   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit t, input bit w, input logic [6:0] c,
                              input bit clr, input bit rn, input bit lp);
        bit         was_full;
        bit         take;
        logic [6:0] head;
        if (!rn) begin
            m_q.delete();
            m_gap    = 1'b0;
            m_ticks  = 0;
            m_strobe = 1'b0;
            m_char   = '0;
            m_ovf    = 1'b0;
            return;
        end
        was_full = (m_q.size() == DEPTH);
        take     = !m_gap && (m_q.size() != 0);
        head     = take ? m_q[0] : 7'h00;
        if (take) begin
            m_gap   = 1'b1;
            m_ticks = 0;
            m_char  = head;
        end else if (m_gap && t && !m_strobe) begin
            m_ticks++;
            if (m_ticks == GAP) m_gap = 1'b0;
        end
        m_strobe = take;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (take) void'(m_q.pop_front());
            if (lp) begin
                if (take) m_q.push_back(head);
            end else if (w) begin
                if (was_full) m_ovf = 1'b1;
                else          m_q.push_back(c);
            end
        end
    endtask

    task automatic step(input bit t, input bit w, input logic [6:0] c,
                        input bit clr, input bit rn, input bit lp);
        rst_n   = rn;
        tick    = t;
        wr_en   = w;
        wr_char = c;
        clear   = clr;
`ifdef SEG_SENDER_LOOP_EN
        loop_en = lp;
`endif
        if (m_strobe || !rn) ticks_since = 0;
        else if (t)          ticks_since++;
        @(posedge clk);
        model_edge(t, w, c, clr, rn, lp);
        #1;
        cyc++;
        check("char_available", 32'(char_available), 32'(m_strobe));
        check("char_out",       32'(char_out),       32'(m_char));
        check("busy",           32'(busy),           32'(m_gap));
        check("full",           32'(full),           32'(m_q.size() == DEPTH));
        check("empty",          32'(empty),          32'(m_q.size() == 0));
        check("overflow",       32'(overflow),       32'(m_ovf));
        if (m_strobe) begin
            if (seen) begin
                if (exact_gap) check("gap_exact", 32'(ticks_since), 32'(GAP));
                else           check("gap_min", 32'(ticks_since >= GAP), 32'd1);
            end
            seen = 1'b1;
            log_q.push_back(m_char);
            last_cyc = cyc;
        end
        if (!rn) seen = 1'b0;
    endtask

    task automatic idle(input int n, input bit t);
        for (int i = 0; i < n; i++) step(t, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int period, input int limit);
        int n = 0;
        while ((m_gap || m_strobe || m_q.size() != 0) && n < limit) begin
            step((cyc % period) == 0, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check("drain_timeout", 32'(n < limit), 32'd1);
    endtask

    initial begin
        step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);

        // single write into an idle sender: strobe two cycles later
        cyc = 0;
        log_q.delete();
        idle(10, 1'b0);
        step(1'b0, 1'b1, 7'h41, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        check("t036_cycle", 32'(last_cyc), 32'd12);
        check("t036_count", 32'(log_q.size()), 32'd1);
        check("t036_busy",  32'(busy), 32'd1);
        drain(1, 50);

        // back-to-back writes paced by a tick every 5 cycles
        seen      = 1'b0;
        exact_gap = 1'b1;
        log_q.delete();
        for (int i = 1; i <= 3; i++) step((cyc % 5) == 0, 1'b1, 7'(i), 1'b0, 1'b1, 1'b0);
        drain(5, 300);
        exact_gap = 1'b0;
        check("t037_count", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) check("t037_order", 32'(log_q[i]), 32'(i + 1));

        // fill during a gap, then one write too many
        log_q.delete();
        step(1'b0, 1'b1, 7'h10, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 7'(8'h20 + i), 1'b0, 1'b1, 1'b0);
        check("t038_full", 32'(full), 32'd1);
        check("t038_ovf0", 32'(overflow), 32'd0);
        step(1'b0, 1'b1, 7'h7F, 1'b0, 1'b1, 1'b0);
        check("t038_ovf1", 32'(overflow), 32'd1);
        drain(1, 500);
        check("t038_count", 32'(log_q.size()), 32'd9);
        for (int i = 0; i < log_q.size(); i++) check("t038_no9th", 32'(log_q[i] == 7'h7F), 32'd0);

        // clear during a gap
        log_q.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 7'(8'h30 + i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0);
        check("t039_empty", 32'(empty), 32'd1);
        check("t039_busy",  32'(busy),  32'd1);
        drain(1, 100);
        idle(10, 1'b1);
        check("t039_strobes", 32'(log_q.size()), 32'd1);

        // reset in the middle of a gap with two queued
        log_q.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'(8'h50 + i), 1'b0, 1'b1, 1'b0);
        check("t040_busy_pre", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0);
        check("t040_char_out", 32'(char_out), 32'd0);
        check("t040_empty",    32'(empty),    32'd1);
        check("t040_busy",     32'(busy),     32'd0);
        idle(20, 1'b1);
        check("t040_quiet", 32'(log_q.size()), 32'd1);
        step(1'b0, 1'b1, 7'h55, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        check("t040_new", 32'(log_q[log_q.size() - 1]), 32'h55);
        drain(1, 50);

        // randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 7'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 499) != 0, 1'b0);
        end
        drain(1, 500);

`ifdef SEG_SENDER_LOOP_EN
        log_q.delete();
        step(1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 7'h0A, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 7'h0B, 1'b0, 1'b1, 1'b0);
        begin
            int n = 0;
            while (log_q.size() < 6 && n < 400) begin
                step(1'b1, 1'b1, 7'h7F, 1'b0, 1'b1, 1'b1);
                n++;
            end
            check("t041_timeout", 32'(n < 400), 32'd1);
        end
        check("t041_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < log_q.size(); i++)
            check("t041_seq", 32'(log_q[i]), (i % 2) == 1 ? 32'h0A : 32'h0B);
        step(1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1);
        drain(1, 50);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_char_sender.md
SEG_CHAR_SENDER -- requirements
Module: seg_char_sender

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter GAP_TICKS, default 30, tick strobes between characters; 1..255.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tick  input  1  single-cycle pacing strobe, e.g. 60 Hz.
REQ-006 SHALL have port wr_en  input  1  write strobe for wr_char.
REQ-007 SHALL have port wr_char  input  7  character code to enqueue.
REQ-008 SHALL have port clear  input  1  synchronous FIFO flush.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port overflow  output  1  sticky, set on a dropped write.
REQ-012 SHALL have port char_available  output  1  one-cycle strobe to the animator's charAvailable input.
REQ-013 SHALL have port char_out  output  7  character to the animator's charInput; held stable between strobes.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement a 2-state FSM: IDLE and GAP.
REQ-016 In IDLE with empty=0, SHALL on the next edge pop the head, load char_out, pulse char_available for exactly one cycle, clear the tick counter, and enter GAP.
REQ-017 In GAP, SHALL increment the tick counter on each tick=1 cycle and return to IDLE on the edge where the count reaches GAP_TICKS.
REQ-018 A write in cycle N into an empty FIFO while in IDLE SHALL produce char_available=1 in cycle N+2.
REQ-019 SHALL keep consecutive char_available pulses at least GAP_TICKS ticks apart; tick in the strobe cycle is not counted.
REQ-020 SHALL accept a write iff wr_en=1 and full=0 in that cycle; a simultaneous pop does not free space for that write.
REQ-021 A write with full=1 SHALL be dropped, FIFO unchanged, overflow set to 1.
REQ-022 SHALL use a count of width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-023 Simultaneous accepted write and pop SHALL leave the count unchanged.
REQ-024 clear=1 SHALL empty the FIFO, clear overflow, and drop any same-cycle write.
REQ-025 clear=1 SHALL NOT abort GAP or alter char_out.
REQ-026 full and empty SHALL be registered and reflect the count after the current edge.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE, count 0, pointers 0, char_out=0, char_available=0, overflow=0, busy=0, full=0, empty=1.
REQ-028 Reset mid-GAP SHALL discard the gap and all queued characters; no strobe is issued in the first cycle after rst_n returns to 1.
REQ-029 FIFO storage SHALL need no reset; unread entries are never visible.

Configuration
REQ-030 SEG_SENDER_LOOP_EN defined SHALL add input port loop_en  1  recirculate mode.
REQ-031 With loop_en=1, each pop SHALL re-push the same character at the tail in the same cycle, leaving the count unchanged.
REQ-032 With loop_en=1, wr_en SHALL be ignored and overflow SHALL NOT set.
REQ-033 With SEG_SENDER_LOOP_EN undefined, SHALL omit the loop_en port; every pop is destructive.

Structure
REQ-034 Package seg_pkg SHALL hold CHAR_W=7, the FSM state enum, and the DEPTH and GAP_TICKS defaults.
REQ-035 SHALL instantiate one sub-module, seg_char_fifo, holding storage, pointers, count, full, empty and overflow; FSM and tick counter stay in the top.

Verification
REQ-036 Write 0x41 in cycle 10 with idle FIFO -> char_available=1 with char_out=0x41 in cycle 12 only; busy=1 from cycle 12.
REQ-037 Write 0x01,0x02,0x03 back-to-back, GAP_TICKS=3, tick every 5 cycles -> three strobes in order, each pair separated by exactly 3 ticks.
REQ-038 DEPTH=8, fill 8 during GAP, then a 9th write -> full=1, overflow=1, 9th character never emitted.
REQ-039 Queue 4 characters, assert clear during GAP -> empty=1 next cycle; GAP completes; no further strobes.
REQ-040 rst_n=0 for one cycle mid-GAP with 2 characters queued -> all outputs at reset values; no strobe until a new write.
REQ-041 With SEG_SENDER_LOOP_EN, load 0x0A,0x0B, set loop_en=1 -> strobes repeat 0x0A,0x0B,0x0A,0x0B; wr_en ignored.
